// File: rtl/ss_scan_driver.sv
// Time-multiplexed N-digit hex seven-segment driver with dead time between digits,
// per-digit dp/blanking, leading-zero blanking and frame-synchronous value update.
//
// state    | meaning
// ST_BLANK | all anodes off for BLANK_CYCLES (anti-ghosting dead time)
// ST_ON    | anode of digit idx lit for DIGIT_CYCLES
module ss_scan_driver #(
  parameter int N_DIGITS       = 4,
  parameter int DIGIT_CYCLES   = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic                  lzb,
  input  logic                  load,
  output logic                  upd_ack,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int MAXC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] DIGIT_TC = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_TC = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGITS - 1);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

  typedef enum logic {ST_BLANK, ST_ON} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [IW-1:0]   idx, idx_nx;
  logic            boundary, xfer;

  logic [4*N_DIGITS-1:0] shadow_data, disp_data, disp_data_nx, upper;
  logic [N_DIGITS-1:0]   shadow_dp, disp_dp, disp_dp_nx;
  logic [N_DIGITS-1:0]   shadow_blank, disp_blank, disp_blank_nx;
  logic                  pending;

  logic [3:0]          nib;
  logic                on_nx, lz_dark, mask_dark, lit_dp;
  logic [6:0]          lit_seg;
  logic [N_DIGITS-1:0] lit_an;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1111110;
      4'h1: hex7 = 7'b0110000;
      4'h2: hex7 = 7'b1101101;
      4'h3: hex7 = 7'b1111001;
      4'h4: hex7 = 7'b0110011;
      4'h5: hex7 = 7'b1011011;
      4'h6: hex7 = 7'b1011111;
      4'h7: hex7 = 7'b1110000;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1111011;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b0011111;
      4'hC: hex7 = 7'b1001110;
      4'hD: hex7 = 7'b0111101;
      4'hE: hex7 = 7'b1001111;
      default: hex7 = 7'b1000111;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    idx_nx   = idx;
    boundary = 1'b0;
    case (state)
      ST_BLANK: if (cnt == BLANK_TC) begin
        state_nx = ST_ON;
        cnt_nx   = '0;
        boundary = (idx == '0);
      end
      ST_ON: if (cnt == DIGIT_TC) begin
        state_nx = ST_BLANK;
        cnt_nx   = '0;
        idx_nx   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
      default: state_nx = ST_BLANK;
    endcase
  end

  // Output flops are fed from next-state values so pins line up with the state cycles.
  always_comb begin
    xfer          = boundary & pending;
    disp_data_nx  = xfer ? shadow_data  : disp_data;
    disp_dp_nx    = xfer ? shadow_dp    : disp_dp;
    disp_blank_nx = xfer ? shadow_blank : disp_blank;
    on_nx         = (state_nx == ST_ON);
    nib           = disp_data_nx[{idx_nx, 2'b00} +: 4];
    upper         = disp_data_nx >> {idx_nx, 2'b00};
    lz_dark       = lzb && (idx_nx != '0) && (upper == '0);
    mask_dark     = disp_blank_nx[idx_nx];
    lit_an        = on_nx ? ({{(N_DIGITS-1){1'b0}}, 1'b1} << idx_nx) : '0;
    lit_seg       = (on_nx && !mask_dark && !lz_dark) ? hex7(nib) : 7'b0;
    lit_dp        = on_nx && !mask_dark && disp_dp_nx[idx_nx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_data  <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      disp_data    <= '0;
      disp_dp      <= '0;
      disp_blank   <= '0;
      pending      <= 1'b0;
      upd_ack      <= 1'b0;
      an           <= {N_DIGITS{AN_INV}};
      seg          <= {7{SEG_INV}};
      dp           <= SEG_INV;
    end else begin
      if (load) begin
        shadow_data  <= data_in;
        shadow_dp    <= dp_in;
        shadow_blank <= blank_mask;
      end
      // A load coinciding with the transfer stays pending for the following frame.
      pending    <= load | (pending & ~xfer);
      disp_data  <= disp_data_nx;
      disp_dp    <= disp_dp_nx;
      disp_blank <= disp_blank_nx;
      upd_ack    <= xfer;
      an         <= lit_an ^ {N_DIGITS{AN_INV}};
      seg        <= lit_seg ^ {7{SEG_INV}};
      dp         <= lit_dp ^ SEG_INV;
    end
  end

endmodule

// File: tb/tb_ss_scan_driver.sv
// Bench for ss_scan_driver: two polarity variants share stimulus; a scoreboard queue
// holds the expected display per frame and monitors check scan timing and digits.
module tb_ss_scan_driver;
  localparam int N  = 4;
  localparam int DC = 4;
  localparam int BC = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_mask = '0;
  logic        lzb = 1'b0;
  logic        load = 1'b0;

  logic        upd_ack_lo, upd_ack_hi, dp_lo, dp_hi;
  logic [3:0]  an_lo, an_hi;
  logic [6:0]  seg_lo, seg_hi;

  ss_scan_driver #(.N_DIGITS(N), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC),
                   .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_lo (
    .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in), .blank_mask(blank_mask),
    .lzb(lzb), .load(load), .upd_ack(upd_ack_lo), .an(an_lo), .seg(seg_lo), .dp(dp_lo));

  ss_scan_driver #(.N_DIGITS(N), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC),
                   .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut_hi (
    .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in), .blank_mask(blank_mask),
    .lzb(lzb), .load(load), .upd_ack(upd_ack_hi), .an(an_hi), .seg(seg_hi), .dp(dp_hi));

  always #5 clk = ~clk;

  // seg holds lit patterns {d3,d2,d1,d0}, dp holds lit dp bits {d3..d0}
  typedef struct packed { logic [27:0] seg; logic [3:0] dp; } rec_t;
  localparam rec_t ZERO_REC = {{4{7'b1111110}}, 4'b0000};

  rec_t  exp_q[$];
  rec_t  cur;
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  int    ack_lo = 0;
  int    ack_hi = 0;
  string nm[2] = '{"lo", "hi"};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int first1(input logic [3:0] v);
    for (int k = 0; k < 4; k++) if (v[k]) return k;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic load_val(input logic [15:0] d, input logic [3:0] p, input logic [3:0] m);
    data_in = d; dp_in = p; blank_mask = m; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Scoreboard monitor: upd_ack pops the next expected frame; each digit visit is compared.
  initial begin : monitor
    logic [3:0] la[2];
    logic [6:0] ls[2];
    logic       ld[2];
    logic [3:0] prev[2];
    int d;
    cur = ZERO_REC;
    prev[0] = '0; prev[1] = '0;
    forever begin
      @(negedge clk);
      la[0] = ~an_lo; ls[0] = ~seg_lo; ld[0] = ~dp_lo;
      la[1] = an_hi;  ls[1] = seg_hi;  ld[1] = dp_hi;
      if (reset) begin
        cur = ZERO_REC;
        prev[0] = '0; prev[1] = '0;
      end else begin
        if (upd_ack_lo) begin
          ack_lo++;
          chk("upd_ack has queued expectation", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) cur = exp_q.pop_front();
        end
        if (upd_ack_hi) ack_hi++;
        for (int i = 0; i < 2; i++) begin
          if (la[i] != 0 && prev[i] == 0) begin
            d = first1(la[i]);
            chk($sformatf("%s seg d%0d", nm[i], d), 32'(ls[i]), 32'(cur.seg[7*d +: 7]));
            chk($sformatf("%s dp d%0d", nm[i], d), 32'(ld[i]), 32'(cur.dp[d]));
          end
          prev[i] = la[i];
        end
      end
    end
  end

  // Scan timing: exclusivity, dead time, on time and digit order on every cycle.
  initial begin : timing
    logic [3:0] a, pv[2];
    int brun[2], orun[2], nextd[2];
    for (int i = 0; i < 2; i++) begin pv[i] = '0; brun[i] = 0; orun[i] = 0; nextd[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        a = (i == 0) ? ~an_lo : an_hi;
        if (reset) begin
          pv[i] = '0; brun[i] = 0; orun[i] = 0; nextd[i] = 0;
        end else begin
          chk($sformatf("%s an at most one", nm[i]), 32'($countones(a) <= 1), 1);
          if (a == 0) begin
            if (orun[i] > 0) begin
              chk($sformatf("%s on length", nm[i]), orun[i], DC);
              orun[i] = 0;
            end
            brun[i]++;
          end else if (pv[i] == 0) begin
            chk($sformatf("%s dead time", nm[i]), brun[i], BC);
            chk($sformatf("%s scan order", nm[i]), first1(a), nextd[i]);
            nextd[i] = (first1(a) + 1) % N;
            brun[i] = 0;
            orun[i] = 1;
          end else begin
            chk($sformatf("%s anode stable", nm[i]), 32'(a), 32'(pv[i]));
            orun[i]++;
          end
          pv[i] = a;
        end
      end
    end
  end

  initial begin : stimulus
    logic [3:0] an_tab[10];
    logic [3:0] inv;
    an_tab = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD};

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    cyc = 0;
    chk("lo an after reset", 32'(an_lo), 32'hF);
    chk("lo seg after reset", 32'(seg_lo), 32'h7F);
    chk("lo dp after reset", 32'(dp_lo), 1);
    chk("lo upd_ack after reset", 32'(upd_ack_lo), 0);
    chk("hi an after reset", 32'(an_hi), 0);
    chk("hi seg after reset", 32'(seg_hi), 0);
    chk("hi dp after reset", 32'(dp_hi), 0);
    chk("hi upd_ack after reset", 32'(upd_ack_hi), 0);
    for (int c = 1; c < 10; c++) begin
      tick();
      inv = ~an_tab[c];
      chk($sformatf("lo an cycle %0d", c), 32'(an_lo), 32'(an_tab[c]));
      chk($sformatf("hi an cycle %0d", c), 32'(an_hi), 32'(inv));
    end

    // pending value must be dropped by a mid-scan reset
    run_to(12);
    load_val(16'hFFFF, 4'hF, 4'h0);
    run_to(14);
    reset = 1'b1;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    cyc = 0;
    chk("lo an after mid-scan reset", 32'(an_lo), 32'hF);
    chk("hi an after mid-scan reset", 32'(an_hi), 0);

    run_to(5);
    exp_q.push_back({7'b0110000, 7'b1101101, 7'b1110111, 7'b1000111, 4'b0000});
    load_val(16'h12AF, 4'h0, 4'h0);
    run_to(45);

    lzb = 1'b1;
    run_to(47);
    exp_q.push_back({7'b0000000, 7'b0000000, 7'b1011011, 7'b1111110, 4'b1000});
    load_val(16'h0050, 4'b1000, 4'h0);
    run_to(87);
    exp_q.push_back({7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110, 4'b0000});
    load_val(16'h0000, 4'h0, 4'h0);
    run_to(127);

    // X pending, Y loaded on the boundary edge itself
    exp_q.push_back({7'b1110000, 7'b1111111, 7'b1111011, 7'b1111110, 4'b0101});
    load_val(16'h7890, 4'b0101, 4'h0);
    run_to(140);
    exp_q.push_back({7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111, 4'b0000});
    load_val(16'hBCDE, 4'h0, 4'h0);
    run_to(185);

    // three loads in one frame: only the last reaches the display
    load_val(16'h1111, 4'h0, 4'h0);
    run_to(190);
    load_val(16'h2222, 4'h0, 4'h0);
    run_to(195);
    exp_q.push_back({7'b0110011, 7'b0000000, 7'b1011111, 7'b1110000, 4'b0000});
    load_val(16'h4567, 4'b0100, 4'b0100);
    run_to(225);

    chk("lo upd_ack count", ack_lo, 6);
    chk("hi upd_ack count", ack_hi, 6);
    chk("expectations left", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ss_scan_driver.md
Name: ss_scan_driver

Overview:
- Parametrised successor to the single-digit 0..2 seven-segment decoder: a time-multiplexed N-digit hex display driver for common-anode/cathode boards.
- Full 0-F decode, per-digit decimal point, per-digit blanking, optional leading-zero blanking.
- Anti-ghosting dead time between digits.
- Tear-free value update: a new value is captured at any time but shown only from the start of the next frame.
- Sits between the system datapath (counters, FSM status) and the board display pins.

Parameters:
- N_DIGITS, 4, number of digits scanned (2..8).
- DIGIT_CYCLES, 50000, clock cycles each digit is lit (>=1).
- BLANK_CYCLES, 500, dead-time cycles with all anodes off between digits (>=1).
- SEG_ACTIVE_LOW, 1, 1: seg/dp driven 0 to light; 0: driven 1 to light.
- AN_ACTIVE_LOW, 1, 1: an driven 0 to enable a digit; 0: driven 1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  4*N_DIGITS  hex nibbles; nibble k (bits 4k+3:4k) goes to digit k; digit 0 is rightmost.
- dp_in  in  N_DIGITS  decimal point enable per digit, 1 = lit.
- blank_mask  in  N_DIGITS  1 = force digit dark.
- lzb  in  1  leading-zero blanking enable.
- load  in  1  single-cycle strobe; captures data_in, dp_in and blank_mask into the shadow register.
- upd_ack  out  1  one-cycle pulse when the shadow register is transferred to the display register.
- an  out  N_DIGITS  digit enables; at most one active at any cycle.
- seg  out  7  segments a..g, with a as bit 6 and g as bit 0.
- dp  out  1  decimal point segment.

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high.

- Reset values:
  - an, seg and dp all driven to their inactive level.
  - upd_ack = 0.
  - Shadow and display registers = 0; pending = 0.
  - FSM in BLANK with digit index 0 and cycle counter 0.

- FSM, two states:
  - BLANK: all anodes inactive; lasts BLANK_CYCLES cycles, then goes to ON.
  - ON: only an[index] active; lasts DIGIT_CYCLES cycles, then goes to BLANK and index increments, wrapping N_DIGITS-1 -> 0.
  - Outputs are registered, so an, seg and dp reflect the current state in exactly the cycles counted for that state.

- Timing:
  - First ON, for digit 0, starts BLANK_CYCLES cycles after reset deasserts.
  - Frame period = N_DIGITS * (DIGIT_CYCLES + BLANK_CYCLES).

- Decode, lit pattern a..g before polarity:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
  - With SEG_ACTIVE_LOW=1, seg is the bitwise inverse (e.g. 0 -> 0000001).

- Blanking: a digit is dark (seg and dp all off, anode still scanned) if either of these holds:
  - its display blank_mask bit is set;
  - lzb=1, digit k>0, and the display nibbles k..N_DIGITS-1 are all zero.
  - Digit 0 is never blanked by lzb.
  - dp follows the display dp bit unless the digit is blanked by blank_mask; lzb does not suppress dp.

- Update path:
  - load=1 writes the shadow register and sets pending.
  - Frame boundary = the BLANK->ON transition with index 0. At the boundary, if pending: display <= shadow, pending cleared, upd_ack = 1 for that one cycle.
  - load in the same cycle as the boundary transfer: the old shadow is transferred, the new value is captured, and pending stays 1, so it is shown next frame.
  - Multiple loads within a frame: last one wins; only one upd_ack.

- Reset mid-scan: takes effect on the next edge; returns to the reset state and discards any pending value.

- Counter widths: clog2(max(DIGIT_CYCLES, BLANK_CYCLES)+1). The index counter saturates nowhere; it wraps only.

Test Plan:
1. Reset mid-scan; params N_DIGITS=4, DIGIT_CYCLES=4, BLANK_CYCLES=1.
   - Required: an=1111, seg=1111111, dp=1, upd_ack=0 on the cycle after reset.
   - Required: an[0]=0 first during cycles 1-4 after release.
   - Required: an=1111 at cycle 5, an[1]=0 at cycles 6-9, frame period 20.
2. load with data_in=16'h12AF, lzb=0 mid-frame.
   - Required: no change until the next frame boundary, then upd_ack pulses once.
   - Required digit patterns: digit0 seg=0111000 (F), digit1 0001000 (A), digit2 0010010 (2), digit3 1001111 (1).
3. lzb=1, data_in=16'h0050, dp_in=4'b1000.
   - Required: digits 3 and 2 dark except digit 3 dp=0; digit1 shows 5 (0100100); digit0 shows 0 (0000001).
   - data_in=16'h0000 -> only digit 0 lit, showing 0.
4. load asserted exactly on the boundary cycle with a prior pending value X and new value Y.
   - Required: X shown this frame with one upd_ack; Y shown next frame with a second upd_ack.
   - Three loads within one frame -> exactly one upd_ack, and the last value is shown.
5. Dead time and exclusivity, checked on every cycle over 3 frames.
   - Required: at most one an bit active, and an all-inactive for exactly BLANK_CYCLES between digits.
   - blank_mask=4'b0100 -> digit 2 dark with its anode still in the scan.
   - Repeat with SEG_ACTIVE_LOW=0 and AN_ACTIVE_LOW=0: all levels inverted.
